// File: rtl/ad9361_spi_pkg.sv
// ad9361_spi_pkg: shared FSM state type, frame geometry and the frame builder
// used by the AD9361 SPI master and its SCLK generator.
package ad9361_spi_pkg;

  // Transaction phases of one 24-bit register access.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } spi_state_e;

  // Frame length and instruction-word field positions.
  localparam int unsigned AD9361_SPI_NBITS = 24;
  localparam int unsigned WR_BIT           = 23;
  localparam int unsigned CNT_MSB          = 22;
  localparam int unsigned ADDR_LSB         = 8;

  // Assemble the MSB-first frame: R/W, byte count (single byte = 000),
  // two reserved zeros, 10-bit address, then the data byte (zero on reads).
  function automatic logic [AD9361_SPI_NBITS-1:0] build_frame(
    input logic       wr,
    input logic [9:0] addr,
    input logic [7:0] wdata
  );
    logic [AD9361_SPI_NBITS-1:0] frame;
    frame                = '0;
    frame[WR_BIT]        = wr;
    frame[CNT_MSB -: 3]  = 3'b000;
    frame[ADDR_LSB +: 10] = addr;
    frame[7:0]           = wr ? wdata : 8'h00;
    return frame;
  endfunction

endpackage

// File: rtl/ad9361_spi_sclk_gen.sv
// ad9361_spi_sclk_gen: SCLK divider for the AD9361 SPI master.
// While enabled, SCLK toggles every CLK_DIV cycles starting with a rising
// edge on the first enabled cycle. rise_stb/fall_stb are high on the cycle
// whose clock edge makes SCLK rise/fall. When disabled, SCLK is forced low
// and the divider is parked at zero so the next enable rises immediately.
module ad9361_spi_sclk_gen import ad9361_spi_pkg::*; #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            sclk_q, sclk_d;

  assign rise_stb = en && (div_q == '0) && !sclk_q;
  assign fall_stb = en && (div_q == '0) && sclk_q;
  assign sclk     = sclk_q;

  // Next-state: reload and toggle at each half-period boundary.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (div_q == '0) begin
      div_d  = DivLast;
      sclk_d = !sclk_q;
    end else begin
      div_d = div_q - 1'b1;
    end
  end

  // Divider and SCLK registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/ad9361_spi_master.sv
// ad9361_spi_master: serialises single-register read/write requests into
// 24-bit AD9361 SPI frames (SPI mode 0, MSB first) and returns the read byte.
// Optional feature macro AD9361_SPI_MISO_SYNC_EN: adds a 2-flop MISO
// synchroniser and moves the MISO sample point two cycles after SCLK rises.
// CLK_DIV must be >= 2 (>= 3 with AD9361_SPI_MISO_SYNC_EN).
module ad9361_spi_master import ad9361_spi_pkg::*; #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [9:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       ad9361_spi_cs,
  output logic       ad9361_spi_sclk,
  output logic       ad9361_spi_mosi,
  input  logic       ad9361_spi_miso
);

  localparam int unsigned NB  = AD9361_SPI_NBITS;
  localparam int unsigned PhW = $clog2(CLK_DIV + 1);
  // SETUP spends one extra cycle so CS falls one cycle after the accept edge.
  localparam logic [PhW-1:0] PhSetup = PhW'(CLK_DIV);
  localparam logic [PhW-1:0] PhLast  = PhW'(CLK_DIV - 1);

  spi_state_e      state_q, state_d;
  logic [PhW-1:0]  phase_q, phase_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic            done_q, done_d;
  logic [NB-1:0]   tx_sr_q, tx_sr_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic            wr_q, wr_d;
  logic            cs_q, cs_d;
  logic            mosi_q, mosi_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;

  logic gen_en;
  logic rise_stb;
  logic fall_stb;
  logic sample_pt;
  logic sample_now;
  logic miso_s;

  // The generator starts on the last SETUP cycle so the first rise lands
  // exactly one divider period after CS falls; it stops once all 24 bits fell.
  assign gen_en = ((state_q == StSetup) && (phase_q == '0)) ||
                  ((state_q == StShift) && !done_q);

  ad9361_spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (gen_en),
    .sclk     (ad9361_spi_sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Only the last 8 rising edges carry the read byte.
  assign sample_pt = rise_stb && (bit_cnt_q < 5'd8);

`ifdef AD9361_SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_q;
  logic [1:0] sample_dly_q;

  // MISO synchroniser with a matching delay on the sample strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      miso_sync_q  <= '0;
      sample_dly_q <= '0;
    end else begin
      miso_sync_q  <= {miso_sync_q[0], ad9361_spi_miso};
      sample_dly_q <= {sample_dly_q[0], sample_pt};
    end
  end

  assign miso_s     = miso_sync_q[1];
  assign sample_now = sample_dly_q[1];
`else
  assign miso_s     = ad9361_spi_miso;
  assign sample_now = sample_pt;
`endif

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = done_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    wr_d        = wr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    if (sample_now) begin
      rx_sr_d = {rx_sr_q[6:0], miso_s};
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d   = StSetup;
          phase_d   = PhSetup;
          bit_cnt_d = 5'(NB - 1);
          done_d    = 1'b0;
          tx_sr_d   = build_frame(req_wr, req_addr, req_wdata);
          rx_sr_d   = 8'h00;
          wr_d      = req_wr;
        end
      end
      StSetup: begin
        if (phase_q == '0) begin
          state_d = StShift;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      StShift: begin
        if (!done_q) begin
          if (fall_stb) begin
            tx_sr_d = {tx_sr_q[NB-2:0], 1'b0};
            if (bit_cnt_q == 5'd0) begin
              // Last fall: let SCLK finish its low half-period before HOLD.
              done_d  = 1'b1;
              phase_d = PhLast;
            end else begin
              bit_cnt_d = bit_cnt_q - 5'd1;
            end
          end
        end else if (phase_q == '0) begin
          state_d = StHold;
          phase_d = PhLast;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      StHold: begin
        if (phase_q == '0) begin
          state_d     = StGap;
          phase_d     = PhLast;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? 8'h00 : rx_sr_q;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      StGap: begin
        if (phase_q == '0) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // CS stays high on the accept edge itself and throughout GAP/IDLE.
    cs_d   = (state_d == StIdle) || (state_d == StGap) || (state_q == StIdle);
    mosi_d = cs_d ? 1'b0 : tx_sr_d[NB-1];
  end

  // State and output registers; reset discards any frame in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_cnt_q   <= 5'd0;
      done_q      <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= 8'h00;
      wr_q        <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready       = (state_q == StIdle);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign ad9361_spi_cs   = cs_q;
  assign ad9361_spi_mosi = mosi_q;

endmodule

// File: tb/tb_ad9361_spi_master.sv
// tb_ad9361_spi_master: directed, table-driven bench for ad9361_spi_master.
// Uses CLK_DIV=3 when AD9361_SPI_MISO_SYNC_EN is defined, otherwise 4.
module tb_ad9361_spi_master;

`ifdef AD9361_SPI_MISO_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 4;
`endif

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  miso;
    logic [23:0] frame;
    logic [7:0]  rdata;
    bit          poke;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [9:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       ad9361_spi_cs;
  logic       ad9361_spi_sclk;
  logic       ad9361_spi_mosi;
  logic       ad9361_spi_miso = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] miso_byte = 8'h00;
  int         fall_n = 0;

  vec_t vecs[6];

  always #5 sys_clk = ~sys_clk;

  ad9361_spi_master #(
    .CLK_DIV(D)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .ad9361_spi_cs  (ad9361_spi_cs),
    .ad9361_spi_sclk(ad9361_spi_sclk),
    .ad9361_spi_mosi(ad9361_spi_mosi),
    .ad9361_spi_miso(ad9361_spi_miso)
  );

  // Device model: drives read bits 7..0 after the falls preceding rises 16..23.
  always @(negedge ad9361_spi_cs) begin
    fall_n = 0;
    ad9361_spi_miso = 1'b0;
  end

  always @(negedge ad9361_spi_sclk) begin
    if (!ad9361_spi_cs) begin
      fall_n++;
      if (fall_n >= 16 && fall_n <= 23) ad9361_spi_miso = miso_byte[23 - fall_n];
      else ad9361_spi_miso = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction, timed from the accept edge (cycle 0).
  task automatic run_frame(input vec_t v, input string tag);
    int cs_fall, cs_rise, first_rise, last_fall, rises, falls;
    int rsp_cnt, rsp_cyc, ready_cyc, idle_bad;
    logic [7:0]  rsp_data;
    logic [23:0] frame;
    logic        p_cs, p_sclk;
    cs_fall = -1; cs_rise = -1; first_rise = -1; last_fall = -1;
    rises = 0; falls = 0; rsp_cnt = 0; rsp_cyc = -1; ready_cyc = -1; idle_bad = 0;
    rsp_data = 8'h00; frame = '0;
    miso_byte = v.miso;
    @(negedge sys_clk);
    check({tag, "_ready_before"}, req_ready, 1);
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    check({tag, "_cs_c0"}, ad9361_spi_cs, 1);
    check({tag, "_ready_c0"}, req_ready, 0);
    p_cs = ad9361_spi_cs; p_sclk = ad9361_spi_sclk;
    for (int c = 1; c <= 1 + 51 * D; c++) begin
      @(posedge sys_clk); #1;
      if (v.poke) begin
        if (c == 40 || c == 51 * D) begin
          req_valid = 1'b1; req_wr = ~v.wr; req_addr = 10'h3FF; req_wdata = 8'hFF;
        end
        if (c == 41 || c == 1 + 51 * D) req_valid = 1'b0;
      end
      if (p_cs && !ad9361_spi_cs && cs_fall < 0) cs_fall = c;
      if (!p_cs && ad9361_spi_cs && cs_rise < 0) cs_rise = c;
      if (!p_sclk && ad9361_spi_sclk) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        frame = {frame[22:0], ad9361_spi_mosi};
      end
      if (p_sclk && !ad9361_spi_sclk) begin
        falls++;
        last_fall = c;
      end
      if (rsp_valid) begin
        rsp_cnt++; rsp_cyc = c; rsp_data = rsp_rdata;
      end
      if (req_ready && ready_cyc < 0) ready_cyc = c;
      p_cs = ad9361_spi_cs; p_sclk = ad9361_spi_sclk;
    end
    for (int c = 0; c < 2 * D; c++) begin
      @(posedge sys_clk); #1;
      if (!ad9361_spi_cs || ad9361_spi_sclk || ad9361_spi_mosi || rsp_valid) idle_bad++;
    end
    check({tag, "_cs_fall"}, cs_fall, 1);
    check({tag, "_first_rise"}, first_rise, 1 + D);
    check({tag, "_rises"}, rises, 24);
    check({tag, "_falls"}, falls, 24);
    check({tag, "_last_fall"}, last_fall, 1 + 48 * D);
    check({tag, "_mosi_frame"}, frame, v.frame);
    check({tag, "_cs_rise"}, cs_rise, 1 + 50 * D);
    check({tag, "_rsp_cnt"}, rsp_cnt, 1);
    check({tag, "_rsp_cyc"}, rsp_cyc, 1 + 50 * D);
    check({tag, "_rsp_rdata"}, rsp_data, v.rdata);
    check({tag, "_ready_cyc"}, ready_cyc, 1 + 51 * D);
    check({tag, "_idle_after"}, idle_bad, 0);
  endtask

  initial begin
    int frames, rsps, min_gap, high_run, rises, bad;
    logic p_cs, p_sclk;

    vecs[0] = '{1'b1, 10'h037, 8'h5A, 8'h00, 24'h80375A, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 10'h037, 8'h77, 8'h0A, 24'h003700, 8'h0A, 1'b0};
    vecs[2] = '{1'b1, 10'h3FF, 8'hFF, 8'hFF, 24'h83FFFF, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 10'h200, 8'hFF, 8'hC3, 24'h020000, 8'hC3, 1'b1};
    vecs[4] = '{1'b1, 10'h001, 8'h00, 8'h00, 24'h800100, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 10'h155, 8'h00, 8'hA5, 24'h015500, 8'hA5, 1'b0};

    // Reset values.
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rst_cs", ad9361_spi_cs, 1);
    check("rst_sclk", ad9361_spi_sclk, 0);
    check("rst_mosi", ad9361_spi_mosi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_ready", req_ready, 1);

    foreach (vecs[i]) run_frame(vecs[i], $sformatf("v%0d", i));

    // req_valid held high: exactly three frames, separated by CS-high gaps.
    @(negedge sys_clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h010; req_wdata = 8'h11;
    frames = 0; rsps = 0; min_gap = 1000000; high_run = 0;
    p_cs = ad9361_spi_cs;
    for (int c = 0; c < 3 * (2 + 51 * D) + 4 * D; c++) begin
      @(posedge sys_clk); #1;
      if (!ad9361_spi_cs) begin
        if (p_cs) begin
          frames++;
          if (frames > 1 && high_run < min_gap) min_gap = high_run;
          if (frames == 3) req_valid = 1'b0;
        end
        high_run = 0;
      end else begin
        high_run++;
      end
      if (rsp_valid) rsps++;
      p_cs = ad9361_spi_cs;
    end
    req_valid = 1'b0;
    check("b2b_frames", frames, 3);
    check("b2b_rsp_pulses", rsps, 3);
    check("b2b_gap_ge_div", (min_gap >= D) ? 1 : 0, 1);

    // Reset at the 10th SCLK rise of a read frame.
    miso_byte = 8'h0A;
    @(negedge sys_clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h037; req_wdata = 8'h00;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    rises = 0; p_sclk = ad9361_spi_sclk;
    for (int c = 0; c < 2000 && rises < 10; c++) begin
      @(posedge sys_clk); #1;
      if (!p_sclk && ad9361_spi_sclk) rises++;
      p_sclk = ad9361_spi_sclk;
    end
    check("rst_mid_reached_rise10", rises, 10);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_cs", ad9361_spi_cs, 1);
    check("rst_mid_sclk", ad9361_spi_sclk, 0);
    check("rst_mid_mosi", ad9361_spi_mosi, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_ready", req_ready, 1);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 60 * D; c++) begin
      @(posedge sys_clk); #1;
      if (rsp_valid || !ad9361_spi_cs || ad9361_spi_sclk) bad++;
    end
    check("rst_mid_no_rsp", bad, 0);
    run_frame(vecs[1], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
